crc16_check: RTL and testbench

CRC16_CHECK -- requirements
Module: crc16_check

---
 rtl/crc16_check_if.sv | 37 +++
 rtl/crc16_check.sv | 138 +++++++++++++
 tb/tb_crc16_check.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/crc16_check_if.sv
// -----------------------------------------------------------------------------
// crc16_check_if
// Byte-stream and status bundle for the CRC-16/MAXIM frame checker.
//
//   clear    master->slave  synchronous frame restart
//   inValid  master->slave  byte offered on inDat this cycle
//   inIsCrc  master->slave  0 = payload byte, 1 = received CRC byte
//   inDat    master->slave  received byte, bit 0 first on the wire
//   ready    slave->master  checker accepts a byte this cycle
//   done     slave->master  frame check complete, holds until clear
//   crcOk    slave->master  both CRC bytes matched (valid while done)
//   crcErr   slave->master  mismatch or sequence error (valid while done)
//   crcReg   slave->master  running CRC register, non-inverted
//   byteCnt  slave->master  payload bytes accepted, saturating at 255
// -----------------------------------------------------------------------------
interface crc16_check_if;
    logic        clear;
    logic        inValid;
    logic        inIsCrc;
    logic [7:0]  inDat;
    logic        ready;
    logic        done;
    logic        crcOk;
    logic        crcErr;
    logic [15:0] crcReg;
    logic [7:0]  byteCnt;

    modport master (
        output clear, inValid, inIsCrc, inDat,
        input  ready, done, crcOk, crcErr, crcReg, byteCnt
    );

    modport slave (
        input  clear, inValid, inIsCrc, inDat,
        output ready, done, crcOk, crcErr, crcReg, byteCnt
    );
endinterface

// File: rtl/crc16_check.sv
// -----------------------------------------------------------------------------
// crc16_check
// Checks a received frame against CRC-16/MAXIM (poly 0xA001 reflected,
// init 0x0000, LSB first, final inversion). Payload bytes are folded into the
// register one bit per clock; the two trailing CRC bytes (low byte first) are
// compared against the inverted register.
//
// Ports:
//   clk   rising-edge clock
//   nRst  asynchronous, active-low reset
//   bus   crc16_check_if.slave: byte input handshake and check status
// -----------------------------------------------------------------------------
module crc16_check (
    input  logic              clk,
    input  logic              nRst,
    crc16_check_if.slave      bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        WAIT_HI = 2'd2,
        DONE    = 2'd3
    } stateT;

    localparam logic [15:0] POLY = 16'hA001;

    stateT       state;
    logic [15:0] crcR;
    logic [7:0]  cntR;
    logic [7:0]  dataR;     // payload byte being shifted, consumed LSB first
    logic [2:0]  bitCnt;
    logic        loMatch;
    logic        readyR;
    logic        doneR;
    logic        okR;
    logic        errR;

    logic        feedback;
    logic        hiMatch;

    assign feedback = crcR[0] ^ dataR[0];
    // Transmitted CRC is the complement of the register, low byte first.
    assign hiMatch  = (bus.inDat == ~crcR[15:8]);

    // NOTE: every register below is assigned with <= so all of them sample the
    // same pre-edge values; a blocking assignment here would let later
    // statements see half-updated state.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state   <= IDLE;
            crcR    <= '0;
            cntR    <= '0;
            dataR   <= '0;
            bitCnt  <= '0;
            loMatch <= 1'b0;
            readyR  <= 1'b1;
            doneR   <= 1'b0;
            okR     <= 1'b0;
            errR    <= 1'b0;
        end else if (bus.clear) begin
            // Restart wins over any byte offered in the same cycle and aborts a
            // byte that is part-way through SHIFT.
            state   <= IDLE;
            crcR    <= '0;
            cntR    <= '0;
            dataR   <= '0;
            bitCnt  <= '0;
            loMatch <= 1'b0;
            readyR  <= 1'b1;
            doneR   <= 1'b0;
            okR     <= 1'b0;
            errR    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.inValid) begin
                        if (bus.inIsCrc) begin
                            loMatch <= (bus.inDat == ~crcR[7:0]);
                            state   <= WAIT_HI;
                        end else begin
                            dataR  <= bus.inDat;
                            bitCnt <= '0;
                            if (cntR != 8'hFF)
                                cntR <= cntR + 8'd1;
                            state  <= SHIFT;
                            readyR <= 1'b0;
                        end
                    end
                end

                SHIFT: begin
                    crcR   <= {1'b0, crcR[15:1]} ^ (feedback ? POLY : 16'h0000);
                    dataR  <= {1'b0, dataR[7:1]};
                    bitCnt <= bitCnt + 3'd1;
                    if (bitCnt == 3'd7) begin
                        state  <= IDLE;
                        readyR <= 1'b1;
                    end
                end

                WAIT_HI: begin
                    if (bus.inValid) begin
                        state  <= DONE;
                        readyR <= 1'b0;
                        doneR  <= 1'b1;
                        if (bus.inIsCrc) begin
                            okR  <= loMatch & hiMatch;
                            errR <= ~(loMatch & hiMatch);
                        end else begin
                            // Payload after the low CRC byte: sequence error,
                            // register and count are left as they were.
                            okR  <= 1'b0;
                            errR <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    // Everything holds until clear.
                end

                default: begin
                    state  <= IDLE;
                    readyR <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready   = readyR;
    assign bus.done    = doneR;
    assign bus.crcOk   = okR;
    assign bus.crcErr  = errR;
    assign bus.crcReg  = crcR;
    assign bus.byteCnt = cntR;

endmodule

// File: tb/tb_crc16_check.sv
// -----------------------------------------------------------------------------
// tb_crc16_check
// Self-checking bench for crc16_check. Each frame pushes its expected final
// status to a scoreboard queue; the entry is popped and compared when the DUT
// raises done. Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_crc16_check;

    logic clk = 1'b0;
    logic nRst;

    crc16_check_if bus();

    crc16_check dut (
        .clk  (clk),
        .nRst (nRst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] crc;
        logic [7:0]  cnt;
        logic        ok;
        logic        err;
    } expT;

    expT        sbQ[$];
    logic [7:0] payQ[$];
    int         testCnt = 0;
    int         failCnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testCnt++;
        if (got !== exp) begin
            failCnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference CRC-16/MAXIM byte update (register form, non-inverted).
    function automatic logic [15:0] crcByte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 16'hA001;
            else             r = r >> 1;
        end
        return r;
    endfunction

    task automatic pushExp(input logic [15:0] crc, input logic [7:0] cnt, input logic ok, input logic err);
        expT e;
        e.crc = crc; e.cnt = cnt; e.ok = ok; e.err = err;
        sbQ.push_back(e);
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic sendByte(input logic isCrc, input logic [7:0] d);
        int waitCyc = 0;
        while (bus.ready !== 1'b1 && waitCyc < 40) begin
            @(negedge clk);
            waitCyc++;
        end
        if (bus.ready !== 1'b1) check("readyTimeout", {31'd0, bus.ready}, 32'd1);
        bus.inValid = 1'b1;
        bus.inIsCrc = isCrc;
        bus.inDat   = d;
        @(negedge clk);
        bus.inValid = 1'b0;
        bus.inIsCrc = 1'b0;
    endtask

    task automatic clearFrame;
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
    endtask

    task automatic waitDone(input string tag);
        expT e;
        int  waitCyc = 0;
        while (bus.done !== 1'b1 && waitCyc < 40) begin
            @(negedge clk);
            waitCyc++;
        end
        check({tag, "_done"}, {31'd0, bus.done}, 32'd1);
        check({tag, "_sbDepth"}, sbQ.size(), 32'd1);
        if (sbQ.size() == 0) return;
        e = sbQ.pop_front();
        check({tag, "_crc"}, {16'd0, bus.crcReg}, {16'd0, e.crc});
        check({tag, "_cnt"}, {24'd0, bus.byteCnt}, {24'd0, e.cnt});
        check({tag, "_ok"}, {31'd0, bus.crcOk}, {31'd0, e.ok});
        check({tag, "_err"}, {31'd0, bus.crcErr}, {31'd0, e.err});
        check({tag, "_ready"}, {31'd0, bus.ready}, 32'd0);
    endtask

    // Sends payQ plus its CRC bytes, optionally corrupted by XOR masks.
    task automatic sendFrame(input string tag, input logic [7:0] loAdj, input logic [7:0] hiAdj);
        logic [15:0] c = 16'h0000;
        int          n;
        n = payQ.size();
        foreach (payQ[i]) c = crcByte(c, payQ[i]);
        foreach (payQ[i]) sendByte(1'b0, payQ[i]);
        sendByte(1'b1, ~c[7:0] ^ loAdj);
        pushExp(c, (n > 255) ? 8'hFF : n[7:0], (loAdj == 0 && hiAdj == 0),
                !(loAdj == 0 && hiAdj == 0));
        sendByte(1'b1, ~c[15:8] ^ hiAdj);
        waitDone(tag);
    endtask

    initial begin
        int          busy;
        int          accepts;
        logic [15:0] mc;

        nRst = 1'b0;
        bus.clear = 1'b0; bus.inValid = 1'b0; bus.inIsCrc = 1'b0; bus.inDat = '0;
        repeat (3) @(negedge clk);

        // Reset state while nRst is held low.
        check("rst_ready", {31'd0, bus.ready}, 32'd1);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_ok", {31'd0, bus.crcOk}, 32'd0);
        check("rst_err", {31'd0, bus.crcErr}, 32'd0);
        check("rst_crc", {16'd0, bus.crcReg}, 32'h0);
        check("rst_cnt", {24'd0, bus.byteCnt}, 32'h0);
        nRst = 1'b1;
        @(negedge clk);

        // Single payload byte 0x01: 8 busy cycles, then register 0xC0C1.
        sendByte(1'b0, 8'h01);
        busy = 0;
        repeat (8) begin
            if (bus.ready === 1'b0) busy++;
            @(negedge clk);
        end
        check("one_busy", busy, 32'd8);
        check("one_readyBack", {31'd0, bus.ready}, 32'd1);
        check("one_crc", {16'd0, bus.crcReg}, 32'hC0C1);
        check("one_cnt", {24'd0, bus.byteCnt}, 32'd1);
        sendByte(1'b1, 8'h3E);
        check("one_waitHiReady", {31'd0, bus.ready}, 32'd1);
        check("one_waitHiDone", {31'd0, bus.done}, 32'd0);
        check("one_waitHiOk", {31'd0, bus.crcOk}, 32'd0);
        check("one_waitHiErr", {31'd0, bus.crcErr}, 32'd0);
        pushExp(16'hC0C1, 8'd1, 1'b1, 1'b0);
        sendByte(1'b1, 8'h3F);
        waitDone("one");

        // "123456789": register 0xBB3D, so the wire carries 0xC2 then 0x44.
        clearFrame();
        for (int i = 0; i < 9; i++) sendByte(1'b0, 8'h31 + i[7:0]);
        sendByte(1'b1, 8'hC2);
        pushExp(16'hBB3D, 8'd9, 1'b1, 1'b0);
        sendByte(1'b1, 8'h44);
        waitDone("ascii");

        // Bad high byte, then bytes offered while done are ignored.
        clearFrame();
        sendByte(1'b0, 8'h01);
        sendByte(1'b1, 8'h3E);
        pushExp(16'hC0C1, 8'd1, 1'b0, 1'b1);
        sendByte(1'b1, 8'h3E);
        waitDone("badHi");
        bus.inValid = 1'b1; bus.inIsCrc = 1'b0; bus.inDat = 8'h77;
        repeat (5) @(negedge clk);
        bus.inValid = 1'b0;
        check("hold_crc", {16'd0, bus.crcReg}, 32'hC0C1);
        check("hold_cnt", {24'd0, bus.byteCnt}, 32'd1);
        check("hold_done", {31'd0, bus.done}, 32'd1);
        check("hold_err", {31'd0, bus.crcErr}, 32'd1);

        // Payload byte after the low CRC byte: sequence error.
        clearFrame();
        check("clr_done", {31'd0, bus.done}, 32'd0);
        check("clr_err", {31'd0, bus.crcErr}, 32'd0);
        sendByte(1'b0, 8'h01);
        sendByte(1'b1, 8'h3E);
        pushExp(16'hC0C1, 8'd1, 1'b0, 1'b1);
        sendByte(1'b0, 8'h55);
        waitDone("seqErr");

        // inValid held high: one acceptance per 9-cycle window.
        clearFrame();
        bus.inValid = 1'b1; bus.inIsCrc = 1'b0; bus.inDat = 8'hA5;
        accepts = 0;
        repeat (27) begin
            if (bus.ready === 1'b1) accepts++;
            @(negedge clk);
        end
        bus.inValid = 1'b0;
        mc = crcByte(crcByte(crcByte(16'h0000, 8'hA5), 8'hA5), 8'hA5);
        check("held_accepts", accepts, 32'd3);
        check("held_cnt", {24'd0, bus.byteCnt}, 32'd3);
        check("held_crc", {16'd0, bus.crcReg}, {16'd0, mc});

        // Clear mid-SHIFT aborts the byte.
        sendByte(1'b0, 8'h5A);
        repeat (3) @(negedge clk);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        check("midClr_crc", {16'd0, bus.crcReg}, 32'h0);
        check("midClr_cnt", {24'd0, bus.byteCnt}, 32'h0);
        check("midClr_ready", {31'd0, bus.ready}, 32'd1);
        @(negedge clk);
        check("midClr_crcLater", {16'd0, bus.crcReg}, 32'h0);

        // Clear together with a byte: the byte is dropped.
        bus.clear = 1'b1; bus.inValid = 1'b1; bus.inDat = 8'h33;
        @(negedge clk);
        bus.clear = 1'b0; bus.inValid = 1'b0;
        check("clrWin_cnt", {24'd0, bus.byteCnt}, 32'h0);
        check("clrWin_ready", {31'd0, bus.ready}, 32'd1);

        // Zero-payload frame.
        pushExp(16'h0000, 8'd0, 1'b1, 1'b0);
        sendByte(1'b1, 8'hFF);
        sendByte(1'b1, 8'hFF);
        waitDone("empty");

        // Random frames, some with corrupted CRC bytes.
        for (int f = 0; f < 6; f++) begin
            int len;
            clearFrame();
            payQ.delete();
            len = $urandom_range(0, 6);
            for (int i = 0; i < len; i++) payQ.push_back(8'($urandom));
            sendFrame($sformatf("rnd%0d", f), (f % 3 == 1) ? 8'h01 : 8'h00,
                      (f % 3 == 2) ? 8'h80 : 8'h00);
        end

        // Byte counter saturates at 255.
        clearFrame();
        payQ.delete();
        for (int i = 0; i < 300; i++) payQ.push_back(8'($urandom));
        sendFrame("sat", 8'h00, 8'h00);

        // Reset during WAIT_HI, then a fresh frame.
        clearFrame();
        sendByte(1'b0, 8'h12);
        sendByte(1'b1, 8'h00);
        check("preRst_ready", {31'd0, bus.ready}, 32'd1);
        #2 nRst = 1'b0;
        #1;
        check("midRst_ready", {31'd0, bus.ready}, 32'd1);
        check("midRst_crc", {16'd0, bus.crcReg}, 32'h0);
        check("midRst_cnt", {24'd0, bus.byteCnt}, 32'h0);
        check("midRst_done", {31'd0, bus.done}, 32'd0);
        check("midRst_ok", {31'd0, bus.crcOk}, 32'd0);
        check("midRst_err", {31'd0, bus.crcErr}, 32'd0);
        @(negedge clk);
        nRst = 1'b1;
        @(negedge clk);
        pushExp(16'h0000, 8'd0, 1'b1, 1'b0);
        sendByte(1'b1, 8'hFF);
        sendByte(1'b1, 8'hFF);
        waitDone("postRst");

        $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
